// File: rtl/sector_read_sequencer.sv
// Sector read framing: splits each sector into preamble and data phases, counts bit cells into
// words, and issues a per-word strobe with the flat RAM word address for the sector buffer.
module sector_read_sequencer #(
  parameter int PREAMBLE_USEC    = 250,
  parameter int WORDS_PER_SECTOR = 321,
  parameter int BITS_PER_WORD    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clkenbl_1usec,
  input  logic        clkenbl_read_bit,
  input  logic        clkenbl_sector,
  input  logic        clkenbl_index,
  input  logic [1:0]  Sector_Address,
  input  logic [7:0]  Cylinder_Address,
  input  logic        Head_Select,
  input  logic        drive_ready,
  output logic        sector_busy,
  output logic        data_window,
  output logic        word_strobe,
  output logic [8:0]  word_index,
  output logic [19:0] ram_address,
  output logic        sector_done,
  output logic        sector_overrun,
  output logic        first_after_index
);

  localparam int USEC_W = $clog2(PREAMBLE_USEC + 1);
  localparam int BIT_W  = $clog2(BITS_PER_WORD);
  localparam logic [USEC_W-1:0] USEC_LAST = USEC_W'(PREAMBLE_USEC - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [8:0]        WORD_LAST = 9'(WORDS_PER_SECTOR - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t            state_r, state_next_s;
  logic [USEC_W-1:0] usec_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [8:0]        word_index_r;
  logic [1:0]        sector_latched_r;
  logic              sample_r;
  logic              index_pending_r;
  logic              first_after_index_r;
  logic              word_strobe_r, sector_done_r, sector_overrun_r;
  logic              start_s, overrun_s, strobe_s, last_word_s;

  // Next-state decode; drive loss dominates, then a sector pulse restarts framing from any state.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    overrun_s    = 1'b0;
    strobe_s     = 1'b0;
    last_word_s  = 1'b0;
    if (!drive_ready) begin
      state_next_s = ST_IDLE;
    end else if (clkenbl_sector) begin
      start_s      = 1'b1;
      overrun_s    = (state_r != ST_IDLE);
      state_next_s = ST_PREAMBLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_IDLE;
        end
        ST_PREAMBLE: begin
          if (clkenbl_1usec && (usec_cnt_r == USEC_LAST)) begin
            state_next_s = ST_DATA;
          end else begin
            state_next_s = ST_PREAMBLE;
          end
        end
        ST_DATA: begin
          if (clkenbl_read_bit && (bit_cnt_r == BIT_LAST)) begin
            strobe_s = 1'b1;
            if (word_index_r == WORD_LAST) begin
              last_word_s  = 1'b1;
              state_next_s = ST_DONE;
            end else begin
              state_next_s = ST_DATA;
            end
          end else begin
            state_next_s = ST_DATA;
          end
        end
        ST_DONE: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register and one-cycle pulse outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r          <= ST_IDLE;
      word_strobe_r    <= 1'b0;
      sector_done_r    <= 1'b0;
      sector_overrun_r <= 1'b0;
      sample_r         <= 1'b0;
      sector_latched_r <= 2'd0;
    end else begin
      state_r          <= state_next_s;
      word_strobe_r    <= strobe_s;
      sector_done_r    <= last_word_s;
      sector_overrun_r <= overrun_s;
      sample_r         <= start_s;
      // Sampled one cycle late so sector_and_index has already advanced its address.
      if (sample_r) begin
        sector_latched_r <= Sector_Address;
      end else begin
        sector_latched_r <= sector_latched_r;
      end
    end
  end

  // Counters plus index bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      usec_cnt_r          <= '0;
      bit_cnt_r           <= '0;
      word_index_r        <= 9'd0;
      index_pending_r     <= 1'b0;
      first_after_index_r <= 1'b0;
    end else if (!drive_ready) begin
      usec_cnt_r          <= '0;
      bit_cnt_r           <= '0;
      word_index_r        <= 9'd0;
      index_pending_r     <= 1'b0;
      first_after_index_r <= 1'b0;
    end else if (start_s) begin
      usec_cnt_r          <= '0;
      bit_cnt_r           <= '0;
      word_index_r        <= 9'd0;
      index_pending_r     <= 1'b0;
      first_after_index_r <= index_pending_r | clkenbl_index;
    end else begin
      if (clkenbl_index) begin
        index_pending_r <= 1'b1;
      end else begin
        index_pending_r <= index_pending_r;
      end
      if ((state_r == ST_PREAMBLE) && clkenbl_1usec) begin
        usec_cnt_r <= usec_cnt_r + USEC_W'(1);
      end else begin
        usec_cnt_r <= usec_cnt_r;
      end
      if ((state_r == ST_DATA) && clkenbl_read_bit) begin
        bit_cnt_r <= (bit_cnt_r == BIT_LAST) ? BIT_W'(0) : bit_cnt_r + BIT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      // The completed word stays visible through its strobe cycle, then advances.
      if ((state_r == ST_DATA) && word_strobe_r) begin
        word_index_r <= word_index_r + 9'd1;
      end else begin
        word_index_r <= word_index_r;
      end
      if (state_r == ST_DONE) begin
        first_after_index_r <= 1'b0;
      end else begin
        first_after_index_r <= first_after_index_r;
      end
    end
  end

  assign sector_busy       = (state_r == ST_PREAMBLE) || (state_r == ST_DATA);
  assign data_window       = (state_r == ST_DATA);
  assign word_strobe       = word_strobe_r;
  assign word_index        = word_index_r;
  assign sector_done       = sector_done_r;
  assign sector_overrun    = sector_overrun_r;
  assign first_after_index = first_after_index_r;
  assign ram_address       = {Cylinder_Address, Head_Select, sector_latched_r, word_index_r};

endmodule

// File: tb/tb_sector_read_sequencer.sv
// Randomized and directed bench for sector_read_sequencer, checked every cycle against a
// sector-level model that tracks phase, elapsed microseconds and total data bits counted.
module tb_sector_read_sequencer;

  localparam int PRE = 250;
  localparam int WPS = 321;
  localparam int BPW = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        clkenbl_1usec = 1'b0, clkenbl_read_bit = 1'b0;
  logic        clkenbl_sector = 1'b0, clkenbl_index = 1'b0;
  logic [1:0]  Sector_Address = 2'd0;
  logic [7:0]  Cylinder_Address = 8'd0;
  logic        Head_Select = 1'b0;
  logic        drive_ready = 1'b0;
  logic        sector_busy, data_window, word_strobe, sector_done, sector_overrun, first_after_index;
  logic [8:0]  word_index;
  logic [19:0] ram_address;

  sector_read_sequencer dut (
    .clock(clock), .reset(reset),
    .clkenbl_1usec(clkenbl_1usec), .clkenbl_read_bit(clkenbl_read_bit),
    .clkenbl_sector(clkenbl_sector), .clkenbl_index(clkenbl_index),
    .Sector_Address(Sector_Address), .Cylinder_Address(Cylinder_Address),
    .Head_Select(Head_Select), .drive_ready(drive_ready),
    .sector_busy(sector_busy), .data_window(data_window), .word_strobe(word_strobe),
    .word_index(word_index), .ram_address(ram_address), .sector_done(sector_done),
    .sector_overrun(sector_overrun), .first_after_index(first_after_index)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  bit checking = 1'b0;

  // Model: phase 0 idle, 1 preamble, 2 data, 3 done (one cycle)
  int       m_phase, m_usecs, m_bits;
  bit       m_strobe, m_done, m_over, m_fai, m_pend, m_smp;
  logic [1:0] m_lat;

  task automatic model_reset();
    m_phase = 0; m_usecs = 0; m_bits = 0;
    m_strobe = 0; m_done = 0; m_over = 0; m_fai = 0; m_pend = 0; m_smp = 0;
    m_lat = 2'd0;
  endtask

  task automatic model_step();
    bit do_sample;
    do_sample = m_smp;
    m_smp = 0; m_strobe = 0; m_done = 0; m_over = 0;
    if (do_sample) m_lat = Sector_Address;
    if (!drive_ready) begin
      m_phase = 0; m_usecs = 0; m_bits = 0; m_pend = 0; m_fai = 0;
    end else if (clkenbl_sector) begin
      m_over = (m_phase != 0);
      m_phase = 1; m_usecs = 0; m_bits = 0;
      m_fai = m_pend | clkenbl_index;
      m_pend = 0; m_smp = 1;
    end else begin
      if (clkenbl_index) m_pend = 1;
      if (m_phase == 1) begin
        if (clkenbl_1usec) m_usecs++;
        if (m_usecs == PRE) m_phase = 2;
      end else if (m_phase == 2) begin
        if (clkenbl_read_bit) begin
          m_bits++;
          if (m_bits % BPW == 0) m_strobe = 1;
          if (m_bits == WPS * BPW) begin
            m_phase = 3; m_done = 1;
          end
        end
      end else if (m_phase == 3) begin
        m_phase = 0; m_fai = 0;
      end
    end
  endtask

  function automatic logic [8:0] model_word_index();
    int q;
    q = m_bits / BPW;
    if (m_strobe) return 9'(q - 1);
    return (q > WPS - 1) ? 9'(WPS - 1) : 9'(q);
  endfunction

  logic [8:0]  e_wi;
  logic [19:0] e_ram;
  bit          e_busy, e_win, ok;

  // Cycle compare against the model, plus event counters for the directed checks.
  always @(negedge clock) begin
    if (checking) begin
      e_wi   = model_word_index();
      e_busy = (m_phase == 1) || (m_phase == 2);
      e_win  = (m_phase == 2);
      e_ram  = {Cylinder_Address, Head_Select, m_lat, e_wi};
      ok = (sector_busy == e_busy) && (data_window == e_win) && (word_strobe == m_strobe) &&
           (word_index == e_wi) && (sector_done == m_done) && (sector_overrun == m_over) &&
           (first_after_index == m_fai) && (!m_strobe || (ram_address == e_ram));
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL cycle t=%0t got busy=%b win=%b stb=%b wi=%0d done=%b ovr=%b fai=%b ram=%h | want busy=%b win=%b stb=%b wi=%0d done=%b ovr=%b fai=%b ram=%h",
                 $time, sector_busy, data_window, word_strobe, word_index, sector_done,
                 sector_overrun, first_after_index, ram_address, e_busy, e_win, m_strobe,
                 e_wi, m_done, m_over, m_fai, e_ram);
      end
    end
    if (word_strobe) strobe_cnt++;
    if (sector_done) done_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input bit sec, input bit idx, input bit us, input bit rb);
    clkenbl_sector = sec; clkenbl_index = idx; clkenbl_1usec = us; clkenbl_read_bit = rb;
    @(posedge clock);
    model_step();
    #1;
    clkenbl_sector = 1'b0; clkenbl_index = 1'b0; clkenbl_1usec = 1'b0; clkenbl_read_bit = 1'b0;
  endtask

  int sec_rate;

  initial begin
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", int'(sector_busy), 0);
    chk("reset_word_index", int'(word_index), 0);
    chk("reset_strobe", int'(word_strobe), 0);
    @(negedge clock);
    #2 reset = 1'b1;
    checking = 1'b1;

    // Preamble length and first-word address
    drive_ready = 1'b1; Sector_Address = 2'd2; Cylinder_Address = 8'h05; Head_Select = 1'b1;
    tick(0, 0, 0, 0);
    chk("idle_busy", int'(sector_busy), 0);
    tick(1, 0, 0, 0);
    chk("start_busy", int'(sector_busy), 1);
    chk("start_no_overrun", int'(sector_overrun), 0);
    for (int i = 1; i <= PRE; i++) begin
      tick(0, 0, 1, 1);
      if (i == PRE - 1) chk("window_before_250", int'(data_window), 0);
      if (i == PRE) chk("window_after_250", int'(data_window), 1);
    end
    strobe_cnt = 0; done_cnt = 0;
    for (int b = 1; b <= BPW; b++) begin
      tick(0, 0, 1, 1);
      if (b == BPW - 1) chk("no_strobe_at_15", int'(word_strobe), 0);
    end
    chk("strobe_at_16", int'(word_strobe), 1);
    chk("word0_index", int'(word_index), 0);
    chk("word0_ram_address", int'(ram_address), 32'h0000_5C00);

    // Rest of the sector
    for (int b = 0; b < (WPS - 1) * BPW; b++) tick(0, 0, 0, 1);
    chk("last_strobe", int'(word_strobe), 1);
    chk("last_done", int'(sector_done), 1);
    chk("last_word_index", int'(word_index), 320);
    chk("done_busy", int'(sector_busy), 0);
    tick(0, 0, 0, 0);
    chk("strobe_count", strobe_cnt, 321);
    chk("done_count", done_cnt, 1);
    chk("hold_word_index", int'(word_index), 320);

    // Index before the sector, then overrun at word 100
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    chk("fai_set", int'(first_after_index), 1);
    for (int i = 0; i < PRE; i++) tick(0, 0, 1, 0);
    for (int b = 0; b < 100 * BPW; b++) tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    chk("at_word_100", int'(word_index), 100);
    tick(1, 0, 0, 0);
    chk("overrun_pulse", int'(sector_overrun), 1);
    chk("overrun_word_index", int'(word_index), 0);
    chk("overrun_window", int'(data_window), 0);
    chk("fai_second_sector", int'(first_after_index), 0);

    // Drive loss mid-sector
    for (int i = 0; i < PRE; i++) tick(0, 0, 1, 0);
    for (int b = 0; b < 40; b++) tick(0, 0, 0, 1);
    drive_ready = 1'b0;
    tick(0, 0, 0, 0);
    chk("notready_busy", int'(sector_busy), 0);
    chk("notready_word_index", int'(word_index), 0);
    drive_ready = 1'b1;
    repeat (3) tick(0, 0, 0, 0);
    chk("no_done_after_abort", done_cnt, 1);

    // Asynchronous reset in the middle of data
    tick(1, 0, 0, 0);
    for (int i = 0; i < PRE; i++) tick(0, 0, 1, 0);
    for (int b = 0; b < 20 * BPW + 3; b++) tick(0, 0, 0, 1);
    chk("pre_reset_window", int'(data_window), 1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_busy", int'(sector_busy), 0);
    chk("async_reset_window", int'(data_window), 0);
    chk("async_reset_word_index", int'(word_index), 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    repeat (3) tick(0, 0, 0, 0);
    chk("post_reset_idle", int'(sector_busy), 0);

    // Randomized traffic: dense sector pulses early, then sparse so sectors complete
    for (int i = 0; i < 30000; i++) begin
      sec_rate = (i < 3000) ? 60 : 5000;
      if (!drive_ready) drive_ready = ($urandom_range(0, 9) == 0);
      else drive_ready = ($urandom_range(0, 3999) != 0);
      Sector_Address = 2'($urandom);
      if (i % 64 == 0) begin
        Cylinder_Address = 8'($urandom);
        Head_Select = 1'($urandom);
      end
      tick($urandom_range(0, sec_rate - 1) == 0, $urandom_range(0, 799) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 3) != 0);
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
